// File: rtl/mn_serial_inverter_if.sv
// Handshake and result bundle for mn_serial_inverter: input map stream, output inverse stream,
// flat inverse bus and permutation error flag.
interface mn_serial_inverter_if #(
    parameter int N = 8
);
    localparam int LOG2N = $clog2(N);

    // valid/ready: a beat transfers on a cycle where valid && ready; the sender
    // keeps data stable while valid && !ready.
    logic               in_valid;
    logic               in_ready;
    logic [LOG2N-1:0]   in_data;
    logic               out_valid;
    logic               out_ready;
    logic [LOG2N-1:0]   out_data;
    logic [LOG2N-1:0]   out_idx;
    logic               out_last;
    logic [N*LOG2N-1:0] inv_flat;
    logic               perm_err;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, inv_flat, perm_err
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, inv_flat, perm_err
    );
endinterface

// File: rtl/mn_serial_inverter.sv
// Serial permutation inverter: loads mp[i] one per beat, then streams mn[mp[i]] = i in index order.
// Define PERM_CHECK_EN to build the seen[] duplicate detector that drives perm_err.
module mn_serial_inverter #(
    parameter int N = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    mn_serial_inverter_if.slave    bus,
    output logic                   state_o
);
    localparam int LOG2N = $clog2(N);
    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] ONE      = LOG2N'(1);

    typedef enum logic {
        LOAD  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [LOG2N-1:0] wr_idx_q, wr_idx_d;
    logic [LOG2N-1:0] rd_idx_q, rd_idx_d;
    logic [LOG2N-1:0] mn_q [N];
    logic [LOG2N-1:0] mn_d [N];
    logic             in_fire;
    logic             out_fire;
    logic [N*LOG2N-1:0] flat_w;

`ifdef PERM_CHECK_EN
    logic [N-1:0]     seen_q, seen_d;
    logic             perm_err_q, perm_err_d;
`endif

    assign in_fire  = bus.in_valid  && (state_q == LOAD);
    assign out_fire = bus.out_ready && (state_q == DRAIN);

    always_comb begin
        state_d  = state_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        mn_d     = mn_q;
`ifdef PERM_CHECK_EN
        seen_d     = seen_q;
        perm_err_d = perm_err_q;
`endif
        case (state_q)
            LOAD: begin
                if (in_fire) begin
                    mn_d[bus.in_data] = wr_idx_q;
                    wr_idx_d          = wr_idx_q + ONE;
`ifdef PERM_CHECK_EN
                    if (seen_q[bus.in_data]) perm_err_d = 1'b1;
                    seen_d[bus.in_data] = 1'b1;
`endif
                    if (wr_idx_q == LAST_IDX) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_fire) begin
                    rd_idx_d = rd_idx_q + ONE;
                    // Last beat out: wipe the frame so the next LOAD starts clean.
                    if (rd_idx_q == LAST_IDX) begin
                        state_d = LOAD;
                        for (int k = 0; k < N; k++) mn_d[k] = '0;
`ifdef PERM_CHECK_EN
                        seen_d     = '0;
                        perm_err_d = 1'b0;
`endif
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= LOAD;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            for (int k = 0; k < N; k++) mn_q[k] <= '0;
`ifdef PERM_CHECK_EN
            seen_q     <= '0;
            perm_err_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            mn_q     <= mn_d;
`ifdef PERM_CHECK_EN
            seen_q     <= seen_d;
            perm_err_q <= perm_err_d;
`endif
        end
    end

    always_comb begin
        flat_w = '0;
        for (int k = 0; k < N; k++) flat_w[k*LOG2N +: LOG2N] = mn_q[k];
    end

    assign bus.in_ready  = (state_q == LOAD);
    assign bus.out_valid = (state_q == DRAIN);
    assign bus.out_data  = mn_q[rd_idx_q];
    assign bus.out_idx   = rd_idx_q;
    assign bus.out_last  = (state_q == DRAIN) && (rd_idx_q == LAST_IDX);
    assign bus.inv_flat  = flat_w;
`ifdef PERM_CHECK_EN
    assign bus.perm_err  = perm_err_q;
`else
    assign bus.perm_err  = 1'b0;
`endif
    assign state_o = (state_q == DRAIN);
endmodule
